beam_direction_decoder: RTL and testbench



---
 rtl/beam_direction_decoder.sv | 209 ++++++++++++++++++++
 tb/tb_beam_direction_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/beam_direction_decoder.sv
// rtl/beam_direction_decoder.sv - doorway beam-break sequence decoder producing entry/exit pulses
//
// Synchronizes and debounces two IR beam-break inputs, then follows the
// break order through a crossing FSM so that only a complete crossing
// produces a count pulse.
//
// Ports:
//   clk          - single clock
//   rst          - synchronous active-high reset
//   beam_a_raw   - outer beam, asynchronous, 1 = broken
//   beam_b_raw   - inner beam, asynchronous, 1 = broken
//   entry_sensor - one-cycle pulse per completed A->B crossing
//   exit_sensor  - one-cycle pulse per completed B->A crossing
//   timeout_flag - one-cycle pulse when a crossing is abandoned by timeout
//   busy         - high whenever the FSM is not idle

module beam_direction_decoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic beam_a_raw,
  input  logic beam_b_raw,
  output logic entry_sensor,
  output logic exit_sensor,
  output logic timeout_flag,
  output logic busy
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    IN_A       = 3'd1,
    IN_AB      = 3'd2,
    IN_B       = 3'd3,
    OUT_B      = 3'd4,
    OUT_AB     = 3'd5,
    OUT_A      = 3'd6,
    WAIT_CLEAR = 3'd7
  } state_t;

  // Bit 0 carries beam A, bit 1 carries beam B through the front end.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {beam_b_raw, beam_a_raw};
      sync2 <= sync1;
    end
  end

  // The filtered level moves only after sync2 has disagreed with it on
  // DEBOUNCE_CYCLES consecutive edges; any agreeing edge restarts the count.
  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DBW-1:0] cnt;
    logic           filt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        filt_q <= 1'b0;
      end else if (sync2[i] == filt_q) begin
        cnt <= '0;
      end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync2[i];
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign filt[i] = filt_q;
  end

  // ab[1] = beam A, ab[0] = beam B, so literals read as (a,b).
  logic [1:0] ab;
  assign ab = {filt[0], filt[1]};

  state_t         state;
  state_t         state_d;
  logic [TOW-1:0] dwell;
  logic           entry_d;
  logic           exit_d;
  logic           timeout_d;
  logic           in_crossing;

  assign in_crossing = (state != IDLE) && (state != WAIT_CLEAR);

  // State register, dwell counter and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dwell        <= '0;
      entry_sensor <= 1'b0;
      exit_sensor  <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      state        <= state_d;
      entry_sensor <= entry_d;
      exit_sensor  <= exit_d;
      timeout_flag <= timeout_d;
      if (state_d != state) begin
        dwell <= '0;
      end else if (in_crossing) begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Next-state logic, including the pulse that accompanies a transition.
  always_comb begin
    state_d   = state;
    entry_d   = 1'b0;
    exit_d    = 1'b0;
    timeout_d = 1'b0;

    case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_d = IN_A;
          2'b01:   state_d = OUT_B;
          2'b11:   state_d = WAIT_CLEAR;
          default: state_d = IDLE;
        endcase
      end
      IN_A: begin
        case (ab)
          2'b11:   state_d = IN_AB;
          2'b01:   state_d = IN_B;
          2'b00:   state_d = IDLE;
          default: state_d = IN_A;
        endcase
      end
      IN_AB: begin
        case (ab)
          2'b01:   state_d = IN_B;
          2'b10:   state_d = IN_A;
          2'b00:   state_d = IDLE;
          default: state_d = IN_AB;
        endcase
      end
      IN_B: begin
        case (ab)
          2'b00: begin
            state_d = IDLE;
            entry_d = 1'b1;
          end
          2'b11:   state_d = IN_AB;
          2'b10:   state_d = IN_A;
          default: state_d = IN_B;
        endcase
      end
      OUT_B: begin
        case (ab)
          2'b11:   state_d = OUT_AB;
          2'b10:   state_d = OUT_A;
          2'b00:   state_d = IDLE;
          default: state_d = OUT_B;
        endcase
      end
      OUT_AB: begin
        case (ab)
          2'b10:   state_d = OUT_A;
          2'b01:   state_d = OUT_B;
          2'b00:   state_d = IDLE;
          default: state_d = OUT_AB;
        endcase
      end
      OUT_A: begin
        case (ab)
          2'b00: begin
            state_d = IDLE;
            exit_d  = 1'b1;
          end
          2'b11:   state_d = OUT_AB;
          2'b01:   state_d = OUT_B;
          default: state_d = OUT_A;
        endcase
      end
      WAIT_CLEAR: begin
        if (ab == 2'b00) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A genuine transition on the final dwell cycle takes precedence; the
    // crossing is only abandoned when it would otherwise stay put.
    if (in_crossing && (state_d == state) && (dwell == TOW'(TIMEOUT_CYCLES - 1))) begin
      state_d   = WAIT_CLEAR;
      timeout_d = 1'b1;
    end
  end

  // Output decode.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule

// File: tb/tb_beam_direction_decoder.sv
// tb/tb_beam_direction_decoder.sv - scoreboard bench for beam_direction_decoder
module tb_beam_direction_decoder;

  logic clk;
  logic rst;
  logic beam_a_raw;
  logic beam_b_raw;
  logic entry_sensor;
  logic exit_sensor;
  logic timeout_flag;
  logic busy;

  typedef struct {
    int kind;   // 0 entry, 1 exit, 2 timeout
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t exp_ev;
  int  got_kind;
  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  c0;

  beam_direction_decoder #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .beam_a_raw  (beam_a_raw),
    .beam_b_raw  (beam_b_raw),
    .entry_sensor(entry_sensor),
    .exit_sensor (exit_sensor),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b);
    beam_a_raw = a;
    beam_b_raw = b;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Every pulse seen must match the head of the expected-event queue.
  always @(negedge clk) begin
    if (entry_sensor || exit_sensor || timeout_flag) begin
      chk("pulse_onehot", $countones({entry_sensor, exit_sensor, timeout_flag}), 1);
      got_kind = entry_sensor ? 0 : (exit_sensor ? 1 : 2);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", got_kind, -1);
      end else begin
        exp_ev = exp_q.pop_front();
        chk("pulse_kind", got_kind, exp_ev.kind);
        chk("pulse_cycle", cyc, exp_ev.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0);
    hold(3);
    chk("reset_entry", entry_sensor, 0);
    chk("reset_exit", exit_sensor, 0);
    chk("reset_timeout", timeout_flag, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    hold(5);

    // Entry crossing: pulse 7 edges after final 00 is driven.
    drive(1'b1, 1'b0); hold(20);
    chk("entry_busy_mid", busy, 1);
    drive(1'b1, 1'b1); hold(20);
    drive(1'b0, 1'b1); hold(20);
    drive(1'b0, 1'b0);
    exp_q.push_back('{kind: 0, cyc: cyc + 7});
    hold(20);
    chk("entry_busy_after", busy, 0);
    chk("entry_q_drained", exp_q.size(), 0);

    // Exit crossing.
    drive(1'b0, 1'b1); hold(20);
    drive(1'b1, 1'b1); hold(20);
    drive(1'b1, 1'b0); hold(20);
    drive(1'b0, 1'b0);
    exp_q.push_back('{kind: 1, cyc: cyc + 7});
    hold(20);
    chk("exit_busy_after", busy, 0);
    chk("exit_q_drained", exp_q.size(), 0);

    // Back-out: no pulse expected.
    drive(1'b1, 1'b0); hold(20);
    drive(1'b1, 1'b1); hold(20);
    drive(1'b1, 1'b0); hold(20);
    drive(1'b0, 1'b0); hold(20);
    chk("backout_busy_after", busy, 0);

    // Glitches of 3 and 2 cycles are filtered out.
    drive(1'b1, 1'b0); hold(3);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("glitch3_busy", busy, 0);
      hold(1);
    end
    drive(1'b1, 1'b0); hold(2);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      chk("glitch2_busy", busy, 0);
      hold(1);
    end
    // A 4-cycle pulse passes: IN_A after 7 edges, back out 4 edges later.
    drive(1'b1, 1'b0);
    c0 = cyc;
    hold(4);
    drive(1'b0, 1'b0);
    hold(2);
    chk("glitch4_busy_before", busy, 0);
    hold(1);
    chk("glitch4_cycle", cyc, c0 + 7);
    chk("glitch4_busy", busy, 1);
    hold(5);
    chk("glitch4_busy_after", busy, 0);
    hold(10);

    // Timeout: IN_A entered 7 edges after drive, flag 50 edges later.
    drive(1'b1, 1'b0);
    exp_q.push_back('{kind: 2, cyc: cyc + 57});
    hold(56);
    chk("timeout_busy_in_a", busy, 1);
    hold(44);
    chk("timeout_busy_wait_clear", busy, 1);
    chk("timeout_q_drained", exp_q.size(), 0);
    drive(1'b0, 1'b0);
    hold(6);
    chk("timeout_busy_before_clear", busy, 1);
    hold(2);
    chk("timeout_busy_after", busy, 0);
    hold(10);

    // Reset mid-crossing discards the crossing.
    drive(1'b1, 1'b0); hold(20);
    drive(1'b1, 1'b1); hold(20);
    drive(1'b0, 1'b1); hold(20);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    hold(1);
    chk("rstmid_entry", entry_sensor, 0);
    chk("rstmid_exit", exit_sensor, 0);
    chk("rstmid_timeout", timeout_flag, 0);
    chk("rstmid_busy", busy, 0);
    rst = 1'b0;
    drive(1'b0, 1'b0);
    hold(20);
    chk("rstmid_busy_after", busy, 0);

    chk("final_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
